// File: rtl/regfile_wb_arbiter.sv
// Two-port write-back arbiter for a 32x32 register file with a per-register busy scoreboard.
// Define REGFILE_WB_RR_EN for round-robin tie-break; otherwise port A has fixed priority.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [ADDR_W-1:0]    a_addr,
    input  logic [DATA_W-1:0]    a_data,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [ADDR_W-1:0]    b_addr,
    input  logic [DATA_W-1:0]    b_data,
    output logic [2**ADDR_W-1:0] wr_en,
    output logic [DATA_W-1:0]    wr_data,
    output logic [2**ADDR_W-1:0] busy
);

    localparam int NREG = 2**ADDR_W;

    logic              r_hold_a_v;
    logic [ADDR_W-1:0] r_hold_a_addr;
    logic [DATA_W-1:0] r_hold_a_data;
    logic              r_hold_b_v;
    logic [ADDR_W-1:0] r_hold_b_addr;
    logic [DATA_W-1:0] r_hold_b_data;
    logic [NREG-1:0]   r_wr_en;
    logic [DATA_W-1:0] r_wr_data;

    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_grant_any;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    logic [NREG-1:0]   w_onehot;
    logic [NREG-1:0]   w_busy;

`ifdef REGFILE_WB_RR_EN
    // r_last_b = 1 means B won the most recent contested grant, so A wins the next tie.
    logic r_last_b;

    assign w_grant_a = r_hold_a_v & (!r_hold_b_v | r_last_b);

    always_ff @(posedge clk) begin
        if (clr) begin
            r_last_b <= 1'b1;
        end else if (r_hold_a_v & r_hold_b_v) begin
            r_last_b <= w_grant_b;
        end
    end
`else
    assign w_grant_a = r_hold_a_v;
`endif

    assign w_grant_b   = r_hold_b_v & !w_grant_a;
    assign w_grant_any = w_grant_a | w_grant_b;
    assign w_sel_addr  = w_grant_a ? r_hold_a_addr : r_hold_b_addr;
    assign w_sel_data  = w_grant_a ? r_hold_a_data : r_hold_b_data;

    // Register 0 is hardwired: its writes take a grant slot but never raise an enable.
    assign w_onehot = (w_sel_addr != '0) ? ({{(NREG-1){1'b0}}, 1'b1} << w_sel_addr) : '0;

    // Valid/ready: a transfer happens on a clock edge where x_valid & x_ready are both high.
    // x_ready is high when the holding slot is empty or is being drained this cycle,
    // so a drain and a refill can share one cycle; it never depends on x_valid.
    assign a_ready = !r_hold_a_v | w_grant_a;
    assign b_ready = !r_hold_b_v | w_grant_b;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_hold_a_v <= 1'b0;
        end else if (a_valid & a_ready) begin
            r_hold_a_v    <= 1'b1;
            r_hold_a_addr <= a_addr;
            r_hold_a_data <= a_data;
        end else if (w_grant_a) begin
            r_hold_a_v <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_hold_b_v <= 1'b0;
        end else if (b_valid & b_ready) begin
            r_hold_b_v    <= 1'b1;
            r_hold_b_addr <= b_addr;
            r_hold_b_data <= b_data;
        end else if (w_grant_b) begin
            r_hold_b_v <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_wr_en   <= '0;
            r_wr_data <= '0;
        end else if (w_grant_any) begin
            r_wr_en   <= w_onehot;
            r_wr_data <= w_sel_data;
        end else begin
            r_wr_en <= '0;
        end
    end

    always_comb begin
        w_busy = r_wr_en;
        if (r_hold_a_v) begin
            w_busy[r_hold_a_addr] = 1'b1;
        end
        if (r_hold_b_v) begin
            w_busy[r_hold_b_addr] = 1'b1;
        end
        w_busy[0] = 1'b0;
    end

    assign wr_en   = r_wr_en;
    assign wr_data = r_wr_data;
    assign busy    = w_busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios then random traffic against a
// transaction-level reference model with shadow register files.
module tb_regfile_wb_arbiter;

`ifdef REGFILE_WB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr;
    logic        a_valid, b_valid;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready;
    logic [31:0] wr_en, wr_data, busy;

    regfile_wb_arbiter dut (
        .clk(clk), .clr(clr),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .wr_en(wr_en), .wr_data(wr_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: one pending entry per port, last contested winner, output stage.
    logic        m_init = 1'b0;
    logic        m_hv[2];
    logic [4:0]  m_ha[2];
    logic [31:0] m_hd[2];
    int          m_last;
    int          m_gnt;
    logic        m_rdy[2];
    logic [31:0] m_en, m_data, m_busy;
    logic [31:0] m_rf[32];
    logic [31:0] d_rf[32];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_eval();
        if (m_hv[0] && m_hv[1]) m_gnt = RR ? (1 - m_last) : 0;
        else if (m_hv[0])       m_gnt = 0;
        else if (m_hv[1])       m_gnt = 1;
        else                    m_gnt = -1;
        for (int p = 0; p < 2; p++) m_rdy[p] = !m_hv[p] || (m_gnt == p);
        m_busy = m_en;
        for (int p = 0; p < 2; p++)
            if (m_hv[p] && m_ha[p] != 0) m_busy = m_busy | (32'h1 << m_ha[p]);
    endtask

    task automatic model_step();
        logic        v[2];
        logic [4:0]  ad[2];
        logic [31:0] dt[2];
        v[0] = a_valid; ad[0] = a_addr; dt[0] = a_data;
        v[1] = b_valid; ad[1] = b_addr; dt[1] = b_data;
        for (int r = 0; r < 32; r++) if (m_en[r]) m_rf[r] = m_data;
        if (clr) begin
            m_hv[0] = 1'b0; m_hv[1] = 1'b0;
            m_last = 1; m_en = 32'h0; m_data = 32'h0; m_init = 1'b1;
            return;
        end
        if (m_gnt >= 0) begin
            m_en   = (m_ha[m_gnt] == 0) ? 32'h0 : (32'h1 << m_ha[m_gnt]);
            m_data = m_hd[m_gnt];
            if (m_hv[0] && m_hv[1]) m_last = m_gnt;
        end else begin
            m_en = 32'h0;
        end
        for (int p = 0; p < 2; p++) begin
            if (v[p] && m_rdy[p]) begin
                m_hv[p] = 1'b1; m_ha[p] = ad[p]; m_hd[p] = dt[p];
            end else if (m_gnt == p) begin
                m_hv[p] = 1'b0;
            end
        end
    endtask

    // Called about 1 time unit after inputs change; outputs are settled.
    task automatic settle();
        #1;
        model_eval();
        if (m_init) begin
            check("a_ready", {31'b0, a_ready}, {31'b0, m_rdy[0]});
            check("b_ready", {31'b0, b_ready}, {31'b0, m_rdy[1]});
            check("wr_en",   wr_en,   m_en);
            check("wr_data", wr_data, m_data);
            check("busy",    busy,    m_busy);
        end
    endtask

    task automatic advance();
        if (m_init)
            for (int r = 0; r < 32; r++) if (wr_en[r] === 1'b1) d_rf[r] = wr_data;
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input logic c, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                          input logic bv, input logic [4:0] ba, input logic [31:0] bd);
        clr = c;
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
            settle();
            advance();
        end
    endtask

    int          ra, rb;
    logic [31:0] sa, sb;
    logic        pv[2];
    logic [4:0]  pa[2];
    logic [31:0] pd[2];
    logic        rc;

    initial begin
        for (int r = 0; r < 32; r++) begin m_rf[r] = 32'h0; d_rf[r] = 32'h0; end
        m_hv[0] = 1'b0; m_hv[1] = 1'b0; m_en = 32'h0; m_data = 32'h0; m_last = 1;

        // Reset with both valids high: nothing may be captured.
        set_in(1'b1, 1'b1, 5'd7, 32'h77, 1'b1, 5'd9, 32'h99);
        settle(); advance();
        settle(); advance();
        set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        settle();
        check("rst_wr_en", wr_en, 32'h0);
        check("rst_busy", busy, 32'h0);
        check("rst_ready", {30'b0, a_ready, b_ready}, 32'h3);
        check("rst_wr_data", wr_data, 32'h0);
        advance();
        settle();
        check("rst_no_write", wr_en, 32'h0);
        advance();

        // Single write A -> r5.
        set_in(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        settle(); advance();
        set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        settle();
        check("sw_c1_busy", busy, 32'h20);
        check("sw_c1_wr_en", wr_en, 32'h0);
        advance();
        settle();
        check("sw_c2_wr_en", wr_en, 32'h20);
        check("sw_c2_wr_data", wr_data, 32'hDEADBEEF);
        check("sw_c2_busy", busy, 32'h20);
        advance();
        settle();
        check("sw_c3_busy", busy, 32'h0);
        check("sw_c3_wr_en", wr_en, 32'h0);
        advance();

        // Contention on r3: A first (A wins first tie in both builds), then B.
        set_in(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
        settle(); advance();
        set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        settle();
        check("ct_c1_busy", busy, 32'h8);
        check("ct_c1_b_ready", {31'b0, b_ready}, 32'h0);
        advance();
        settle();
        check("ct_c2_wr_en", wr_en, 32'h8);
        check("ct_c2_wr_data", wr_data, 32'h11);
        advance();
        settle();
        check("ct_c3_wr_en", wr_en, 32'h8);
        check("ct_c3_wr_data", wr_data, 32'h22);
        advance();
        settle();
        check("ct_c4_busy", busy, 32'h0);
        advance();
        check("ct_reg3", d_rf[3], 32'h22);

        // Streaming: both valid every cycle; count ready cycles over cycles 1..8.
        ra = 0; rb = 0; sa = 32'hA0000000; sb = 32'hB0000000;
        for (int k = 0; k < 9; k++) begin
            set_in(1'b0, 1'b1, 5'(8 + (k % 4)), sa, 1'b1, 5'(16 + (k % 4)), sb);
            settle();
            if (k > 0) begin
                ra += a_ready ? 1 : 0;
                rb += b_ready ? 1 : 0;
            end
            if (m_rdy[0]) sa = sa + 1;
            if (m_rdy[1]) sb = sb + 1;
            advance();
        end
        check("st_a_ready_cnt", 32'(ra), RR ? 32'd4 : 32'd8);
        check("st_b_ready_cnt", 32'(rb), RR ? 32'd4 : 32'd0);
        idle(4);

        // Register 0 write from B.
        set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF);
        settle();
        check("r0_b_ready", {31'b0, b_ready}, 32'h1);
        advance();
        set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        settle();
        check("r0_c1_busy", busy, 32'h0);
        advance();
        settle();
        check("r0_c2_wr_en", wr_en, 32'h0);
        advance();
        idle(1);
        check("r0_reg0", d_rf[0], 32'h0);

        // Mid-operation reset: A held, B in output stage.
        set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'hBB);
        settle(); advance();
        set_in(1'b0, 1'b1, 5'd4, 32'hAA, 1'b0, 5'd0, 32'h0);
        settle(); advance();
        set_in(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        settle();
        check("mr_pre_wr_en", wr_en, 32'h40);
        check("mr_pre_busy", busy, 32'h50);
        advance();
        set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        settle();
        check("mr_wr_en", wr_en, 32'h0);
        check("mr_busy", busy, 32'h0);
        check("mr_ready", {30'b0, a_ready, b_ready}, 32'h3);
        advance();
        settle();
        check("mr_no_write", wr_en, 32'h0);
        advance();
        check("mr_reg4", d_rf[4], 32'h0);

        // Random traffic; requests stay valid until accepted.
        pv[0] = 1'b0; pv[1] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pv[p] && $urandom_range(0, 99) < 65) begin
                    pv[p] = 1'b1;
                    pa[p] = 5'($urandom_range(0, 31));
                    pd[p] = $urandom;
                end
            end
            rc = ($urandom_range(0, 63) == 0);
            set_in(rc, pv[0], pa[0], pd[0], pv[1], pa[1], pd[1]);
            settle();
            for (int p = 0; p < 2; p++) if (pv[p] && m_rdy[p] && !rc) pv[p] = 1'b0;
            advance();
        end
        idle(5);
        for (int r = 0; r < 32; r++) check($sformatf("rf[%0d]", r), d_rf[r], m_rf[r]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
